// File: rtl/counter_pkg.sv
// Shared constants for the toggle counter: counting modes and default width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package counter_pkg;

  // Counting behaviour at the MAX_COUNT / 0 limits.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Default counter width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Largest value representable in w bits. The arithmetic is 64 bits wide so
  // that w == 32 does not overflow.
  function automatic logic [63:0] max_for_width(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/toggle_counter_tff_cell.sv
// Vector of T flip-flops: each stage inverts when its toggle bit is set.
// Latency: 1 cycle from t to q.
// Backpressure: none; t is applied on every rising edge.
module tff_cell
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] state_q;

  // Toggle stages: clear asynchronously, otherwise flip every bit whose t is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_q ^ t;
    end
  end

  assign q = state_q;

endmodule

// File: rtl/toggle_counter.sv
// Up/down counter built from toggle stages; wrap or saturate at 0 and MAX_COUNT.
// Latency: 1 cycle from inputs to q and wrap; tc is combinational on q and up.
// Backpressure: none. The optional sticky overflow flag exists only when
// TOGGLE_COUNTER_OVF_EN is defined.
module toggle_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = DEFAULT_WIDTH,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int              SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef TOGGLE_COUNTER_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf
`endif
);

  // Stop elaboration if the configuration cannot be represented.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "toggle_counter: WIDTH must be in 1..32");
  end
  if (MAX_COUNT < 64'd1 || MAX_COUNT > max_for_width(WIDTH)) begin : g_bad_max
    $fatal(1, "toggle_counter: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam bit               SAT   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] dec_t;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] load_tgt;
  logic             at_top;
  logic             at_bot;
  logic             at_limit;
  logic             step_act;
  logic             wrap_d;
  logic             wrap_q;

  assign at_top   = (q_int == MAX_V);
  assign at_bot   = (q_int == '0);
  assign at_limit = up ? at_top : at_bot;
  assign step_act = en && !clear && !load;
  assign load_tgt = (load_val > MAX_V) ? MAX_V : load_val;

  assign q  = q_int;
  assign tc = at_limit;

  // Ripple toggle masks: a bit flips on increment when all lower bits are 1,
  // and on decrement when all lower bits are 0.
  always_comb begin
    inc_t    = '0;
    dec_t    = '0;
    inc_t[0] = 1'b1;
    dec_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_t[i] = inc_t[i-1] & q_int[i-1];
      dec_t[i] = dec_t[i-1] & ~q_int[i-1];
    end
  end

  // Select the toggle mask for this edge: clear > load > count > hold.
  // Clear and load toggle exactly the bits that differ from the target value.
  // Wrapping up from MAX_COUNT toggles the set bits (giving 0); wrapping down
  // from 0 toggles MAX_COUNT's set bits (giving MAX_COUNT).
  always_comb begin
    t_d    = '0;
    wrap_d = 1'b0;
    if (clear) begin
      t_d = q_int;
    end else if (load) begin
      t_d = q_int ^ load_tgt;
    end else if (en) begin
      if (at_limit) begin
        if (!SAT) begin
          t_d    = up ? q_int : MAX_V;
          wrap_d = 1'b1;
        end
      end else begin
        t_d = up ? inc_t : dec_t;
      end
    end
  end

  tff_cell #(
    .WIDTH (WIDTH)
  ) u_tff_cell (
    .clk   (clk),
    .reset (reset),
    .t     (t_d),
    .q     (q_int)
  );

  // Wrap pulse register: high for the single cycle in which q shows the wrapped value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

`ifdef TOGGLE_COUNTER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Sticky overflow: set on any step attempted at a limit; a set in the same
  // cycle wins over ovf_clr. The flag is cleared by ovf_clr or by clear.
  always_comb begin
    ovf_d = ovf_q;
    if (step_act && at_limit) begin
      ovf_d = 1'b1;
    end else if (ovf_clr || clear) begin
      ovf_d = 1'b0;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: a wrap-mode and a saturate-mode instance (WIDTH=4,
// MAX_COUNT=9) driven by the same inputs and checked against an arithmetic model.
// Overflow checks are included when TOGGLE_COUNTER_OVF_EN is defined.
module tb_toggle_counter;

  localparam int MAXC = 9;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q_w;
  logic [3:0] q_s;
  logic       tc_w;
  logic       tc_s;
  logic       wrap_w;
  logic       wrap_s;
`ifdef TOGGLE_COUNTER_OVF_EN
  logic       ovf_clr;
  logic       ovf_w;
  logic       ovf_s;
`endif

  int pass_cnt;
  int total_cnt;

  // Model state, indexed by instance: 0 = wrap mode, 1 = saturate mode.
  int mq[2];
  bit mw[2];
  bit mo[2];

  toggle_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_w (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .q        (q_w),
    .tc       (tc_w),
    .wrap     (wrap_w)
`ifdef TOGGLE_COUNTER_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .ovf      (ovf_w)
`endif
  );

  toggle_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_s (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .q        (q_s),
    .tc       (tc_s),
    .wrap     (wrap_s)
`ifdef TOGGLE_COUNTER_OVF_EN
    ,
    .ovf_clr  (ovf_clr),
    .ovf      (ovf_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m] = 0;
      mw[m] = 0;
      mo[m] = 0;
    end
  endtask

  // Apply one set of inputs across one rising edge; the model advances from the
  // spec rules, and the task returns at the following falling edge.
  task automatic step(input bit e, input bit u, input bit c, input bit l,
                      input logic [3:0] lv, input bit oc);
    bit lim;
    bit act;
    int lvi;
    en = e; up = u; clear = c; load = l; load_val = lv;
`ifdef TOGGLE_COUNTER_OVF_EN
    ovf_clr = oc;
`endif
    @(posedge clk);
    lvi = int'(lv);
    for (int m = 0; m < 2; m++) begin
      lim   = u ? (mq[m] == MAXC) : (mq[m] == 0);
      act   = e && !c && !l;
      mw[m] = act && lim && (m == 0);
      if (act && lim)    mo[m] = 1;
      else if (oc || c)  mo[m] = 0;
      if (c)             mq[m] = 0;
      else if (l)        mq[m] = (lvi > MAXC) ? MAXC : lvi;
      else if (e) begin
        if (lim)         mq[m] = (m == 1) ? mq[m] : (u ? 0 : MAXC);
        else             mq[m] = u ? mq[m] + 1 : mq[m] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b1; load_val = 4'd5;
`ifdef TOGGLE_COUNTER_OVF_EN
    ovf_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({q_w, wrap_w, q_s, wrap_s} !== {4'd0, 1'b0, 4'd0, 1'b0})
      $display("FAIL reset_state: got q_w=%0d wrap_w=%0d q_s=%0d wrap_s=%0d want 0 0 0 0",
               q_w, wrap_w, q_s, wrap_s);
    else pass_cnt++;
    total_cnt++;
    if ({tc_w, tc_s} !== 2'b00)
      $display("FAIL reset_tc_up: got tc_w=%0b tc_s=%0b want 0 0", tc_w, tc_s);
    else pass_cnt++;
    up = 1'b0;
    #1;
    total_cnt++;
    if ({tc_w, tc_s} !== 2'b11)
      $display("FAIL reset_tc_down: got tc_w=%0b tc_s=%0b want 1 1", tc_w, tc_s);
    else pass_cnt++;
`ifdef TOGGLE_COUNTER_OVF_EN
    total_cnt++;
    if ({ovf_w, ovf_s} !== 2'b00)
      $display("FAIL reset_ovf: got %0b%0b want 00", ovf_w, ovf_s);
    else pass_cnt++;
`endif
    load = 1'b0; en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_up_wrap();
    int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 4'd0, 0);
      total_cnt++;
      if ({q_w, wrap_w} !== {4'(exp_q[i]), exp_q[i] == 0})
        $display("FAIL up_wrap[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0b",
                 i, q_w, wrap_w, exp_q[i], exp_q[i] == 0);
      else pass_cnt++;
      total_cnt++;
      if ({q_s, wrap_s, tc_s} !== {4'(mq[1]), 1'b0, mq[1] == MAXC})
        $display("FAIL up_sat[%0d]: got q=%0d wrap=%0b tc=%0b want q=%0d wrap=0 tc=%0b",
                 i, q_s, wrap_s, tc_s, mq[1], mq[1] == MAXC);
      else pass_cnt++;
    end
  endtask

  task automatic test_down_load();
    int exp_q[5] = '{2, 1, 0, 9, 8};
    step(0, 1, 0, 1, 4'd3, 0);
    total_cnt++;
    if ({q_w, wrap_w} !== {4'd3, 1'b0})
      $display("FAIL load3: got q=%0d wrap=%0b want q=3 wrap=0", q_w, wrap_w);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0, 4'd0, 0);
      total_cnt++;
      if ({q_w, wrap_w, tc_w} !== {4'(exp_q[i]), exp_q[i] == 9, exp_q[i] == 0})
        $display("FAIL down[%0d]: got q=%0d wrap=%0b tc=%0b want q=%0d wrap=%0b tc=%0b",
                 i, q_w, wrap_w, tc_w, exp_q[i], exp_q[i] == 9, exp_q[i] == 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    step(0, 1, 0, 1, 4'd8, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 4'd0, 0);
      total_cnt++;
      if ({q_s, wrap_s, tc_s} !== {4'd9, 1'b0, 1'b1})
        $display("FAIL sat_up[%0d]: got q=%0d wrap=%0b tc=%0b want q=9 wrap=0 tc=1",
                 i, q_s, wrap_s, tc_s);
      else pass_cnt++;
      total_cnt++;
      if ({q_w, wrap_w} !== {4'(mq[0]), mw[0]})
        $display("FAIL sat_wrapinst[%0d]: got q=%0d wrap=%0b want q=%0d wrap=%0b",
                 i, q_w, wrap_w, mq[0], mw[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clear_priority();
    step(1, 1, 1, 1, 4'd5, 0);
    total_cnt++;
    if ({q_w, wrap_w, q_s, wrap_s} !== {4'd0, 1'b0, 4'd0, 1'b0})
      $display("FAIL clear_prio: got q_w=%0d wrap_w=%0b q_s=%0d wrap_s=%0b want 0 0 0 0",
               q_w, wrap_w, q_s, wrap_s);
    else pass_cnt++;
    step(0, 1, 0, 1, 4'd15, 0);
    total_cnt++;
    if ({q_w, q_s} !== {4'd9, 4'd9})
      $display("FAIL load_clamp: got q_w=%0d q_s=%0d want 9 9", q_w, q_s);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcount();
    step(0, 1, 0, 1, 4'd7, 0);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({q_w, q_s, wrap_w, wrap_s} !== {4'd0, 4'd0, 1'b0, 1'b0})
      $display("FAIL reset_async: got q_w=%0d q_s=%0d want 0 0", q_w, q_s);
    else pass_cnt++;
    model_reset();
    en = 1'b1; up = 1'b1; load = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step(1, 1, 0, 0, 4'd0, 0);
    total_cnt++;
    if ({q_w, q_s} !== {4'd1, 4'd1})
      $display("FAIL reset_first_count: got q_w=%0d q_s=%0d want 1 1", q_w, q_s);
    else pass_cnt++;
    // A wrap pulse present when reset arrives must disappear at once.
    step(0, 1, 0, 1, 4'd9, 0);
    step(1, 1, 0, 0, 4'd0, 0);
    total_cnt++;
    if ({q_w, wrap_w} !== {4'd0, 1'b1})
      $display("FAIL prewrap: got q=%0d wrap=%0b want q=0 wrap=1", q_w, wrap_w);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (wrap_w !== 1'b0)
      $display("FAIL reset_wrap_discard: got wrap=%0b want 0", wrap_w);
    else pass_cnt++;
    model_reset();
    en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef TOGGLE_COUNTER_OVF_EN
  task automatic test_ovf();
    step(0, 1, 1, 0, 4'd0, 0);
    step(0, 1, 0, 1, 4'd9, 0);
    step(1, 1, 0, 0, 4'd0, 0);
    total_cnt++;
    if ({q_w, ovf_w, ovf_s} !== {4'd0, 1'b1, 1'b1})
      $display("FAIL ovf_set: got q=%0d ovf_w=%0b ovf_s=%0b want 0 1 1", q_w, ovf_w, ovf_s);
    else pass_cnt++;
    step(0, 1, 0, 0, 4'd0, 0);
    total_cnt++;
    if (ovf_w !== 1'b1)
      $display("FAIL ovf_hold: got %0b want 1", ovf_w);
    else pass_cnt++;
    step(0, 1, 0, 1, 4'd9, 0);
    step(1, 1, 0, 0, 4'd0, 1);
    total_cnt++;
    if ({wrap_w, ovf_w} !== 2'b11)
      $display("FAIL ovf_set_wins: got wrap=%0b ovf=%0b want 1 1", wrap_w, ovf_w);
    else pass_cnt++;
    step(0, 1, 0, 0, 4'd0, 1);
    total_cnt++;
    if ({ovf_w, ovf_s} !== 2'b00)
      $display("FAIL ovf_clr: got ovf_w=%0b ovf_s=%0b want 0 0", ovf_w, ovf_s);
    else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    bit e, u, c, l, oc;
    logic [3:0] lv;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1) == 1;
      c  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 9) == 0);
      lv = 4'($urandom_range(0, 15));
      oc = ($urandom_range(0, 7) == 0);
      step(e, u, c, l, lv, oc);
      total_cnt++;
      if ({q_w, wrap_w, tc_w} !== {4'(mq[0]), mw[0], u ? mq[0] == MAXC : mq[0] == 0})
        $display("FAIL rand_wrap[%0d]: got q=%0d wrap=%0b tc=%0b want q=%0d wrap=%0b",
                 i, q_w, wrap_w, tc_w, mq[0], mw[0]);
      else pass_cnt++;
      total_cnt++;
      if ({q_s, wrap_s, tc_s} !== {4'(mq[1]), 1'b0, u ? mq[1] == MAXC : mq[1] == 0})
        $display("FAIL rand_sat[%0d]: got q=%0d wrap=%0b tc=%0b want q=%0d wrap=0",
                 i, q_s, wrap_s, tc_s, mq[1]);
      else pass_cnt++;
`ifdef TOGGLE_COUNTER_OVF_EN
      total_cnt++;
      if ({ovf_w, ovf_s} !== {mo[0], mo[1]})
        $display("FAIL rand_ovf[%0d]: got %0b%0b want %0b%0b", i, ovf_w, ovf_s, mo[0], mo[1]);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_up_wrap();
    test_down_load();
    test_saturate();
    test_clear_priority();
    test_reset_midcount();
`ifdef TOGGLE_COUNTER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (1..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, top count value (1..2**WIDTH-1).
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap mode, 1 = saturate mode.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear  input  1  synchronous clear to 0.
REQ-009 SHALL have port load  input  1  synchronous load of load_val.
REQ-010 SHALL have port load_val  input  WIDTH  value to load.
REQ-011 SHALL have port q  output  WIDTH  registered count.
REQ-012 SHALL have port tc  output  1  combinational terminal count: (up && q==MAX_COUNT) || (!up && q==0).
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse marking a wrap event.

Function
REQ-014 SHALL apply priority per edge: clear > load > en > hold.
REQ-015 SHALL set q to 0 on clear, regardless of load and en.
REQ-016 SHALL load min(load_val, MAX_COUNT) on load without clear; load_val above MAX_COUNT is clamped.
REQ-017 SHALL, with en and no clear/load, step q by +1 (up=1) or -1 (up=0) in exactly one cycle.
REQ-018 SHALL compute each step as a per-bit toggle mask applied to toggle stages (next = q ^ t), not as a direct adder assignment.
REQ-019 SHALL, in wrap mode, go MAX_COUNT->0 counting up and 0->MAX_COUNT counting down.
REQ-020 SHALL, in saturate mode, hold q at MAX_COUNT counting up and at 0 counting down.
REQ-021 SHALL assert wrap for exactly the one cycle in which q holds the wrapped value; wrap is never asserted in saturate mode, nor on clear or load.
REQ-022 SHALL hold q and deassert wrap when en=0 and neither clear nor load is active.
REQ-023 SHALL evaluate a direction change with en asserted against the current q, without a stall cycle.

Reset
REQ-024 SHALL, on reset low, immediately drive q=0 and wrap=0, independent of clk.
REQ-025 SHALL ignore en, clear and load while reset is low; the first count occurs on the first rising edge after deassertion.
REQ-026 SHALL, on reset mid-count, discard any pending wrap pulse.

Configuration
REQ-027 SHALL compile a sticky overflow feature when macro TOGGLE_COUNTER_OVF_EN is defined.
REQ-028 SHALL, with the macro defined, add ports ovf (output, 1) and ovf_clr (input, 1); ovf sets on any wrap event, or on a saturate-mode attempt past a limit; ovf clears on ovf_clr, clear or reset; set wins over ovf_clr in the same cycle.
REQ-029 SHALL, without the macro, provide neither port and contain no ovf logic; all other behaviour is identical.

Structure
REQ-030 SHALL place mode constants (MODE_WRAP=0, MODE_SAT=1) and the default WIDTH in shared package counter_pkg.
REQ-031 SHALL instantiate sub-module tff_cell (parametrised WIDTH vector of toggle stages: t, clk, reset, q), one instance holding q.
REQ-032 SHALL elaborate with a fatal error when MAX_COUNT is outside 1..2**WIDTH-1.

Verification
REQ-033 SHALL cover: WIDTH=4, MAX_COUNT=9, wrap mode, up, en high 12 cycles from reset -> q 1..9,0,1,2; wrap high only on the cycle q=0.
REQ-034 SHALL cover: same config, load 3, then down 5 cycles -> q 2,1,0,9,8; tc high while q=0; wrap high on the cycle q=9.
REQ-035 SHALL cover: SATURATE=1, MAX_COUNT=9, load 8, up 3 cycles -> q 9,9,9; wrap never high; tc high from q=9.
REQ-036 SHALL cover: clear, load(load_val=5) and en asserted together -> q=0; next cycle load alone with load_val=15 -> q=9 (clamped).
REQ-037 SHALL cover: reset asserted between edges at q=7 -> q=0 immediately; after release, en up -> q=1 on the first edge.
REQ-038 SHALL cover, with TOGGLE_COUNTER_OVF_EN: wrap 9->0 -> ovf=1 and held; ovf_clr in the same cycle as a second wrap -> ovf stays 1; ovf_clr alone -> ovf=0.
